// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the two-requester block-RAM arbiter
package mem_arb_pkg;

  localparam int MEM_ARB_NREQ = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } arb_state_t;

  typedef logic [$clog2(MEM_ARB_NREQ)-1:0] owner_t;

endpackage

// File: rtl/mem_arb_if.sv
// rtl/mem_arb_if.sv - requester and RAM-side signal bundle for mem_arbiter
interface mem_arb_if #(
  parameter int MEM_WIDTH  = 16,
  parameter int ADDER_SIZE = 10
);

  logic                  req_0, req_1;
  logic                  we_0, we_1;
  logic [ADDER_SIZE-1:0] addr_0, addr_1;
  logic [MEM_WIDTH-1:0]  wdata_0, wdata_1;
  logic                  gnt_0, gnt_1;
  logic                  rvalid_0, rvalid_1;
  logic [MEM_WIDTH-1:0]  rdata_0, rdata_1;
  logic                  busy;

  logic                  mem_wr_en, mem_rd_en, mem_blk_select;
  logic [MEM_WIDTH-1:0]  mem_din, mem_dout;
  logic [ADDER_SIZE-1:0] mem_addr_wr, mem_addr_rd;

  // master: the requesters plus the RAM dout pin
  modport master (
    output req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, mem_dout,
    input  gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1, busy,
    input  mem_wr_en, mem_rd_en, mem_blk_select, mem_din, mem_addr_wr, mem_addr_rd
  );

  modport slave (
    input  req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, mem_dout,
    output gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1, busy,
    output mem_wr_en, mem_rd_en, mem_blk_select, mem_din, mem_addr_wr, mem_addr_rd
  );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select between two requesters
// MEM_ARB_RR_EN selects round-robin tie breaking; otherwise requester 0 has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   req_0,
  input  logic   req_1,
`ifdef MEM_ARB_RR_EN
  input  owner_t last,
`endif
  output logic   valid,
  output owner_t winner
);

  always_comb begin
    valid = req_0 | req_1;
`ifdef MEM_ARB_RR_EN
    // on a tie the requester that did not win last time goes first
    winner = (req_0 && req_1) ? ~last : owner_t'(req_1);
`else
    winner = owner_t'(~req_0 & req_1);
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter in front of a registered-dout block RAM
// MEM_ARB_RR_EN enables round-robin arbitration (fixed priority to requester 0 otherwise).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_WIDTH  = 16,
  parameter int MEM_DEPTH  = 1024,
  parameter int ADDER_SIZE = 10
) (
  input  logic       clk,
  input  logic       rst,
  mem_arb_if.slave   bus
);

  if (MEM_DEPTH != (1 << ADDER_SIZE)) begin : g_bad_depth
    $error("mem_arbiter: MEM_DEPTH must equal 2**ADDER_SIZE");
  end

  arb_state_t            state, state_n;
  owner_t                owner, owner_n;
  logic [1:0]            gnt_q, gnt_n;
  logic [1:0]            rvalid_q, rvalid_n;
  logic                  blk_q, blk_n, wr_q, wr_n, rd_q, rd_n;
  logic [MEM_WIDTH-1:0]  din_q, din_n;
  logic [ADDER_SIZE-1:0] addr_q, addr_n;
`ifdef MEM_ARB_RR_EN
  owner_t                last, last_n;
`endif

  logic                  pick_valid;
  owner_t                pick_winner;
  logic                  sel_we;
  logic [ADDER_SIZE-1:0] sel_addr;
  logic [MEM_WIDTH-1:0]  sel_wdata;

  mem_arb_pick u_pick (
    .req_0  (bus.req_0),
    .req_1  (bus.req_1),
`ifdef MEM_ARB_RR_EN
    .last   (last),
`endif
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign sel_we    = (pick_winner == 1'b1) ? bus.we_1    : bus.we_0;
  assign sel_addr  = (pick_winner == 1'b1) ? bus.addr_1  : bus.addr_0;
  assign sel_wdata = (pick_winner == 1'b1) ? bus.wdata_1 : bus.wdata_0;

  always_comb begin
    state_n  = state;
    owner_n  = owner;
`ifdef MEM_ARB_RR_EN
    last_n   = last;
`endif
    gnt_n    = '0;
    rvalid_n = '0;
    blk_n    = 1'b0;
    wr_n     = 1'b0;
    rd_n     = 1'b0;
    din_n    = '0;
    addr_n   = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n             = ACCESS;
          owner_n             = pick_winner;
`ifdef MEM_ARB_RR_EN
          last_n              = pick_winner;
`endif
          gnt_n[pick_winner]  = 1'b1;
          blk_n               = 1'b1;
          wr_n                = sel_we;
          rd_n                = ~sel_we;
          din_n               = sel_wdata;
          addr_n              = sel_addr;
        end
      end
      ACCESS: state_n = wr_q ? IDLE : RDWAIT;
      RDWAIT: begin
        // RAM dout is loaded at the end of ACCESS; flag it for the owner now
        state_n         = IDLE;
        rvalid_n[owner] = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= '0;
`ifdef MEM_ARB_RR_EN
      last     <= 1'b1;
`endif
      gnt_q    <= '0;
      rvalid_q <= '0;
      blk_q    <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      din_q    <= '0;
      addr_q   <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
`ifdef MEM_ARB_RR_EN
      last     <= last_n;
`endif
      gnt_q    <= gnt_n;
      rvalid_q <= rvalid_n;
      blk_q    <= blk_n;
      wr_q     <= wr_n;
      rd_q     <= rd_n;
      din_q    <= din_n;
      addr_q   <= addr_n;
    end
  end

  assign bus.gnt_0          = gnt_q[0];
  assign bus.gnt_1          = gnt_q[1];
  assign bus.rvalid_0       = rvalid_q[0];
  assign bus.rvalid_1       = rvalid_q[1];
  assign bus.rdata_0        = rvalid_q[0] ? bus.mem_dout : '0;
  assign bus.rdata_1        = rvalid_q[1] ? bus.mem_dout : '0;
  assign bus.busy           = (state != IDLE);
  assign bus.mem_blk_select = blk_q;
  assign bus.mem_wr_en      = wr_q;
  assign bus.mem_rd_en      = rd_q;
  assign bus.mem_din        = din_q;
  assign bus.mem_addr_wr    = addr_q;
  assign bus.mem_addr_rd    = addr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a transaction-level model
module tb_mem_arbiter;

  localparam int W = 16;
  localparam int D = 1024;
  localparam int A = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arb_if #(.MEM_WIDTH(W), .ADDER_SIZE(A)) bus ();

  mem_arbiter #(.MEM_WIDTH(W), .MEM_DEPTH(D), .ADDER_SIZE(A)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] ram [D];
  always @(posedge clk) begin
    if (bus.mem_blk_select) begin
      if (bus.mem_wr_en) ram[bus.mem_addr_wr] <= bus.mem_din;
      if (bus.mem_rd_en) bus.mem_dout <= ram[bus.mem_addr_rd];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [W-1:0] preload(int i);
    return W'(i * 37) ^ 16'hA5A5;
  endfunction

  // Transaction model: one outstanding access, timing derived from its grant edge
  logic [W-1:0] mm [D];
  int           t = 0;
  int           free_edge = 0;
  bit           live = 0;
  bit           have = 0;
  int           g;
  bit           own, twe, last = 1'b1, w;
  logic [A-1:0] taddr;
  logic [W-1:0] twd, trd;
  logic [1:0]   e_gnt, e_rv;
  logic         e_busy, e_blk, e_wr, e_rd;
  logic [A-1:0] e_addr;
  logic [W-1:0] e_din;

  always @(posedge clk) begin
    t++;
    if (!rst) begin
      live = 1; have = 0; free_edge = t + 1; last = 1'b1;
    end else if (t >= free_edge && (bus.req_0 || bus.req_1)) begin
`ifdef MEM_ARB_RR_EN
      w = (bus.req_0 && bus.req_1) ? !last : bus.req_1;
      last = w;
`else
      w = !bus.req_0;
`endif
      have  = 1; g = t; own = w;
      twe   = w ? bus.we_1 : bus.we_0;
      taddr = w ? bus.addr_1 : bus.addr_0;
      twd   = w ? bus.wdata_1 : bus.wdata_0;
      if (twe) mm[taddr] = twd;
      else     trd = mm[taddr];
      free_edge = t + (twe ? 2 : 3);
    end
    e_gnt = '0; e_rv = '0; e_busy = 0; e_blk = 0; e_wr = 0; e_rd = 0; e_addr = '0; e_din = '0;
    if (have) begin
      if (t == g) begin
        e_gnt[own] = 1'b1; e_blk = 1; e_wr = twe; e_rd = !twe; e_addr = taddr; e_din = twd;
      end
      e_busy = (t == g) || (!twe && t == g + 1);
      if (!twe && t == g + 2) e_rv[own] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("gnt",         {bus.gnt_1, bus.gnt_0}, e_gnt);
      chk("rvalid",      {bus.rvalid_1, bus.rvalid_0}, e_rv);
      chk("busy",        bus.busy, e_busy);
      chk("mem_ctl",     {bus.mem_blk_select, bus.mem_wr_en, bus.mem_rd_en}, {e_blk, e_wr, e_rd});
      chk("mem_addr_wr", bus.mem_addr_wr, e_addr);
      chk("mem_addr_rd", bus.mem_addr_rd, e_addr);
      chk("mem_din",     bus.mem_din, e_din);
      if (e_rv[0]) begin chk("rdata_0", bus.rdata_0, trd); chk("rdata_1_idle", bus.rdata_1, 0); end
      if (e_rv[1]) begin chk("rdata_1", bus.rdata_1, trd); chk("rdata_0_idle", bus.rdata_0, 0); end
    end
  end

  task automatic set_req(input int idx, input bit we, input logic [A-1:0] a, input logic [W-1:0] d);
    if (idx == 0) begin bus.req_0 = 1; bus.we_0 = we; bus.addr_0 = a; bus.wdata_0 = d; end
    else          begin bus.req_1 = 1; bus.we_1 = we; bus.addr_1 = a; bus.wdata_1 = d; end
  endtask

  task automatic drop(input int idx);
    if (idx == 0) bus.req_0 = 0; else bus.req_1 = 0;
  endtask

  function automatic bit gnt_of(int idx);
    return idx ? bus.gnt_1 : bus.gnt_0;
  endfunction

  function automatic bit rv_of(int idx);
    return idx ? bus.rvalid_1 : bus.rvalid_0;
  endfunction

  task automatic wait_gnt(input int idx, input int bound, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt_of(idx) && n < bound);
    if (!gnt_of(idx)) chk($sformatf("gnt_%0d_timeout", idx), 0, 1);
  endtask

  task automatic access(input int idx, input bit we, input logic [A-1:0] a, input logic [W-1:0] d,
                        output logic [W-1:0] rd, output int glat, output int rlat);
    rd = '0; rlat = 0;
    set_req(idx, we, a, d);
    wait_gnt(idx, 20, glat);
    drop(idx);
    if (!we) begin
      do begin @(negedge clk); rlat++; end while (!rv_of(idx) && rlat < 10);
      if (!rv_of(idx)) chk($sformatf("rvalid_%0d_timeout", idx), 0, 1);
      rd = idx ? bus.rdata_1 : bus.rdata_0;
    end
  endtask

  task automatic rand_req(input int idx);
    bit           we, abort;
    logic [A-1:0] a;
    int           waited, pick;
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      we    = 1'($urandom_range(0, 1));
      pick  = $urandom_range(0, 7);
      a     = (pick == 0) ? '0 : (pick == 1) ? '1 : A'($urandom_range(0, D - 1));
      abort = ($urandom_range(0, 15) == 0);
      set_req(idx, we, a, W'($urandom));
      waited = 0;
      forever begin
        @(negedge clk); waited++;
        if (gnt_of(idx) || abort) break;
        if (waited >= 200) begin chk($sformatf("rand_gnt_%0d_timeout", idx), 0, 1); break; end
      end
      drop(idx);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] rd;
    int gl, rl, n;
    for (int i = 0; i < D; i++) begin ram[i] = preload(i); mm[i] = preload(i); end
    rst = 0;
    bus.req_0 = 0; bus.req_1 = 0; bus.we_0 = 0; bus.we_1 = 0;
    bus.addr_0 = '0; bus.addr_1 = '0; bus.wdata_0 = '0; bus.wdata_1 = '0;

    // reset held with a pending request
    set_req(0, 0, '0, '0);
    repeat (2) @(negedge clk);
    chk("rst_gnt", {bus.gnt_1, bus.gnt_0}, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_ctl", {bus.mem_blk_select, bus.mem_wr_en, bus.mem_rd_en}, 0);
    chk("rst_rvalid", {bus.rvalid_1, bus.rvalid_0}, 0);
    drop(0); rst = 1;
    @(negedge clk);

    // write then read back
    access(0, 1, 10'h005, 16'hBEEF, rd, gl, rl);
    chk("t2_gnt_lat", gl, 1);
    chk("t2_wr_en", bus.mem_wr_en, 1);
    @(negedge clk);
    chk("t2_wr_en_off", bus.mem_wr_en, 0);
    access(0, 0, 10'h005, '0, rd, gl, rl);
    chk("t2_rd_lat", rl, 2);
    chk("t2_rdata", rd, 16'hBEEF);

    // held tie after reset
    rst = 0; @(negedge clk); rst = 1;
    set_req(0, 0, 10'h010, '0);
    set_req(1, 0, 10'h020, '0);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(bus.gnt_0 || bus.gnt_1) && n < 20);
`ifdef MEM_ARB_RR_EN
      chk($sformatf("t3_tie_%0d", k), {bus.gnt_1, bus.gnt_0}, (k % 2) ? 2'b10 : 2'b01);
`else
      chk($sformatf("t3_tie_%0d", k), {bus.gnt_1, bus.gnt_0}, 2'b01);
`endif
    end
    drop(0);
    wait_gnt(1, 20, n);
    chk("t3_after_drop", bus.gnt_1, 1);
    drop(1);
    repeat (4) @(negedge clk);

    // request raised while busy waits for IDLE
    set_req(0, 0, 10'h005, '0);
    wait_gnt(0, 20, n);
    drop(0);
    @(negedge clk);
    chk("t4_busy", bus.busy, 1);
    set_req(1, 0, 10'h3FF, '0);
    @(negedge clk);
    chk("t4_no_gnt1", bus.gnt_1, 0);
    chk("t4_rvalid0", bus.rvalid_0, 1);
    chk("t4_rdata0", bus.rdata_0, 16'hBEEF);
    @(negedge clk);
    chk("t4_gnt1", bus.gnt_1, 1);
    drop(1);
    repeat (3) @(negedge clk);

    // reset during RDWAIT
    set_req(0, 0, 10'h005, '0);
    wait_gnt(0, 20, n);
    drop(0);
    @(negedge clk);
    chk("t5_busy_rdwait", bus.busy, 1);
    rst = 0;
    @(negedge clk);
    chk("t5_rvalid", bus.rvalid_0, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_rd_en", bus.mem_rd_en, 0);
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("t5_no_late_rvalid_%0d", k), bus.rvalid_0, 0);
    end

    // address extremes
    access(1, 1, 10'h3FF, 16'h1234, rd, gl, rl);
    access(0, 1, 10'h000, 16'hFFFF, rd, gl, rl);
    access(1, 0, 10'h3FF, '0, rd, gl, rl);
    chk("t6_rd_3ff", rd, 16'h1234);
    access(0, 0, 10'h000, '0, rd, gl, rl);
    chk("t6_rd_000", rd, 16'hFFFF);
    repeat (2) @(negedge clk);

    fork
      rand_req(0);
      rand_req(1);
    join
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
